// File: rtl/alu_pkg.sv
// Shared op encodings and flag bit positions for the ALU/register-file pipeline.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_CMP  = 3'b101,
    OP_LOAD = 3'b110,
    OP_NOP  = 3'b111
  } op_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;

  // CMP is a pure compare and NOP does nothing, so neither may touch the register file.
  function automatic logic op_writes(input op_e op);
    return !(op == OP_CMP || op == OP_NOP);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: arithmetic/logic result plus {carry, neg, zero} flags and signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             over
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           lt;
  logic           eq;
  logic           carry;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: the top bit is the NOT-borrow carry of the subtraction
    diff   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    lt     = $signed(a) < $signed(b);
    eq     = (a == b);
    result = '0;
    carry  = 1'b0;
    over   = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        over   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        over   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_CMP:  result = {{(WIDTH-3){1'b0}}, !lt && !eq, eq, lt};
      OP_LOAD: result = imm;
      default: result = '0;
    endcase
    flags             = '0;
    flags[FLAG_CARRY] = carry;
    flags[FLAG_NEG]   = result[WIDTH-1];
    flags[FLAG_ZERO]  = (result == '0);
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU pipeline over a DEPTH x WIDTH register file with write-back forwarding
// and a whole-pipe stall driven by out_ready.
module alu_regfile_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [$clog2(DEPTH)-1:0] addressA,
  input  logic [$clog2(DEPTH)-1:0] addressB,
  input  logic [$clog2(DEPTH)-1:0] addressD,
  input  logic [WIDTH-1:0]         dataIn,
  input  logic                     asel,
  input  logic                     bsel,
  input  logic                     wen,
  input  logic                     oen,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         outPut,
  output logic                     over,
  output logic [2:0]               flags
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_imm_q, s1_imm_d;
  logic             s1_asel_q, s1_asel_d;
  logic             s1_bsel_q, s1_bsel_d;
  logic [AW-1:0]    s1_addr_a_q, s1_addr_a_d;
  logic [AW-1:0]    s1_addr_b_q, s1_addr_b_d;
  logic [AW-1:0]    s1_addr_d_q, s1_addr_d_d;
  logic             s1_wen_q, s1_wen_d;
  logic             s1_oen_q, s1_oen_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic [2:0]       s2_flags_q, s2_flags_d;
  logic             s2_over_q, s2_over_d;
  logic             s2_wr_q, s2_wr_d;
  logic             s2_oen_q, s2_oen_d;
  logic [AW-1:0]    s2_addr_q, s2_addr_d;

  logic             rf_we;
  logic             accept;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] alu_result;
  logic [2:0]       alu_flags;
  logic             alu_over;

  always_comb begin
    in_ready = !(s2_valid_q && !out_ready);
    accept   = in_valid && in_ready;
    rf_we    = s2_valid_q && out_ready && s2_wr_q;
    // A read on the same edge as the retiring write must see the value being written.
    rd_a     = (rf_we && s2_addr_q == addressA) ? s2_result_q : regs_q[addressA];
    rd_b     = (rf_we && s2_addr_q == addressB) ? s2_result_q : regs_q[addressB];
    // S1 operands captured before the S2 command finished take its result instead.
    op_a     = (s1_asel_q && s2_valid_q && s2_wr_q && s2_addr_q == s1_addr_a_q) ? s2_result_q : s1_a_q;
    op_b     = (s1_bsel_q && s2_valid_q && s2_wr_q && s2_addr_q == s1_addr_b_q) ? s2_result_q : s1_b_q;
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (s1_op_q),
    .a      (op_a),
    .b      (op_b),
    .imm    (s1_imm_q),
    .result (alu_result),
    .flags  (alu_flags),
    .over   (alu_over)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_imm_d    = s1_imm_q;
    s1_asel_d   = s1_asel_q;
    s1_bsel_d   = s1_bsel_q;
    s1_addr_a_d = s1_addr_a_q;
    s1_addr_b_d = s1_addr_b_q;
    s1_addr_d_d = s1_addr_d_q;
    s1_wen_d    = s1_wen_q;
    s1_oen_d    = s1_oen_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_op_d     = op_e'(op);
      s1_a_d      = asel ? rd_a : dataIn;
      s1_b_d      = bsel ? rd_b : dataIn;
      s1_imm_d    = dataIn;
      s1_asel_d   = asel;
      s1_bsel_d   = bsel;
      s1_addr_a_d = addressA;
      s1_addr_b_d = addressB;
      s1_addr_d_d = addressD;
      s1_wen_d    = wen;
      s1_oen_d    = oen;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    s2_over_d   = s2_over_q;
    s2_wr_d     = s2_wr_q;
    s2_oen_d    = s2_oen_q;
    s2_addr_d   = s2_addr_q;
    if (in_ready) begin
      s2_valid_d  = s1_valid_q;
      s2_result_d = alu_result;
      s2_flags_d  = alu_flags;
      s2_over_d   = alu_over;
      s2_wr_d     = s1_valid_q && s1_wen_q && op_writes(s1_op_q);
      s2_oen_d    = s1_oen_q;
      s2_addr_d   = s1_addr_d_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_NOP;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_imm_q    <= '0;
      s1_asel_q   <= 1'b0;
      s1_bsel_q   <= 1'b0;
      s1_addr_a_q <= '0;
      s1_addr_b_q <= '0;
      s1_addr_d_q <= '0;
      s1_wen_q    <= 1'b0;
      s1_oen_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
      s2_over_q   <= 1'b0;
      s2_wr_q     <= 1'b0;
      s2_oen_q    <= 1'b0;
      s2_addr_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_imm_q    <= s1_imm_d;
      s1_asel_q   <= s1_asel_d;
      s1_bsel_q   <= s1_bsel_d;
      s1_addr_a_q <= s1_addr_a_d;
      s1_addr_b_q <= s1_addr_b_d;
      s1_addr_d_q <= s1_addr_d_d;
      s1_wen_q    <= s1_wen_d;
      s1_oen_q    <= s1_oen_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
      s2_over_q   <= s2_over_d;
      s2_wr_q     <= s2_wr_d;
      s2_oen_q    <= s2_oen_d;
      s2_addr_q   <= s2_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf_we) begin
      regs_q[s2_addr_q] <= s2_result_q;
    end
  end

  // oen masks only the visible result; write-back and flags use the raw value.
  assign out_valid = s2_valid_q;
  assign outPut    = (s2_valid_q && s2_oen_q) ? s2_result_q : '0;
  assign over      = s2_over_q;
  assign flags     = s2_flags_q;

endmodule
